// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS-subset core: fetch FSM states, reset PC
// default, opcode constants and small PC-arithmetic helpers.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Sign-extended 16-bit branch offset, scaled to a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Next-PC selection for the current instruction: jump > taken branch > pc+4.
// All arithmetic wraps modulo 2^32.
module next_pc_logic
    import cpu_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        Bne,
    input  logic        zero,
    output logic [31:0] next_pc
);

    logic        taken;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        unused_opcode;

    // The opcode is decoded elsewhere; only the immediate/target fields matter here.
    assign unused_opcode = ^instr[31:26];

    assign taken         = Branch & (Bne ? ~zero : zero);
    assign branch_target = pc_plus4 + branch_offset(instr[15:0]);
    assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};

    // Priority mux: a jump overrides any simultaneous branch decision.
    always_comb begin
        next_pc = pc_plus4;
        if (Jump) begin
            next_pc = jump_target;
        end else if (taken) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: IDLE -> FETCH -> EXEC sequencing, instruction
// memory handshake, PC / instruction register / retired counter.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        commit,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        Bne,
    input  logic        zero,
    output logic [31:0] retired
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  retired_q, retired_d;
    logic [31:0]  next_pc;

    next_pc_logic u_next_pc (
        .pc_plus4 (pc_plus4),
        .instr    (instr_q),
        .Jump     (Jump),
        .Branch   (Branch),
        .Bne      (Bne),
        .zero     (zero),
        .next_pc  (next_pc)
    );

    // Next-state logic; ack and commit only matter in their own states.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (commit) begin
                    pc_d      = next_pc;
                    retired_d = retired_q + 32'd1;
                    state_d   = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over any same-edge ack or commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0;
            retired_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == EXEC);
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_hi = 1'b1;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        commit = 1'b0;
    logic        Jump = 1'b0, Branch = 1'b0, Bne = 1'b0, zero = 1'b0;

    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, pc, pc_plus4, retired;

    logic        hi_req, hi_valid;
    logic [31:0] hi_addr, hi_instr, hi_pc, hi_pc_plus4, hi_retired;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
        .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
        .commit(commit), .Jump(Jump), .Branch(Branch), .Bne(Bne),
        .zero(zero), .retired(retired)
    );

    fetch_unit #(.RESET_PC(32'h1000_0000)) u_dut_hi (
        .clk(clk), .rst(rst_hi), .imem_req(hi_req), .imem_addr(hi_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(hi_instr),
        .instr_valid(hi_valid), .pc(hi_pc), .pc_plus4(hi_pc_plus4),
        .commit(commit), .Jump(Jump), .Branch(Branch), .Bne(Bne),
        .zero(zero), .retired(hi_retired)
    );

    typedef struct {
        logic [31:0] ins;
        logic        j;
        logic        b;
        logic        bne;
        logic        z;
        int          delay;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    function automatic logic [31:0] mk_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic wait_req(input bit hi, input string name);
        bit seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (hi ? hi_req : imem_req) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk({name, "_req_timeout"}, {31'h0, seen}, 32'h1);
    endtask

    task automatic set_ctrl(input logic c, input logic j, input logic b, input logic n, input logic z);
        commit = c; Jump = j; Branch = b; Bne = n; zero = z;
    endtask

    initial begin
        logic [31:0] exp_pc;

        vecs[0]  = '{32'h2008_0005,              0, 0, 0, 0, 0, 32'h0000_0004};
        vecs[1]  = '{mk_i(OP_RTYPE, 16'h0020),   0, 0, 0, 0, 0, 32'h0000_0008};
        vecs[2]  = '{mk_i(OP_RTYPE, 16'h0020),   0, 0, 0, 1, 0, 32'h0000_000C};
        vecs[3]  = '{mk_i(OP_RTYPE, 16'h0020),   0, 0, 0, 0, 3, 32'h0000_0010};
        vecs[4]  = '{mk_i(OP_BEQ, 16'hFFFF),     0, 1, 0, 1, 0, 32'h0000_0010};
        vecs[5]  = '{mk_i(OP_BEQ, 16'hFFFF),     0, 1, 0, 0, 0, 32'h0000_0014};
        vecs[6]  = '{mk_j(OP_J, 26'h000_0004),   1, 0, 0, 0, 0, 32'h0000_0010};
        vecs[7]  = '{mk_i(OP_BNE, 16'hFFFF),     0, 1, 1, 1, 0, 32'h0000_0014};
        vecs[8]  = '{mk_j(OP_J, 26'h000_0004),   1, 0, 0, 0, 0, 32'h0000_0010};
        vecs[9]  = '{mk_i(OP_BNE, 16'hFFFF),     0, 1, 1, 0, 0, 32'h0000_0010};
        vecs[10] = '{mk_i(OP_BEQ, 16'hFFFA),     0, 1, 0, 1, 0, 32'hFFFF_FFFC};
        vecs[11] = '{mk_i(OP_RTYPE, 16'h0020),   0, 0, 0, 0, 0, 32'h0000_0000};
        vecs[12] = '{mk_j(OP_J, 26'h000_0040),   1, 1, 0, 1, 0, 32'h0000_0100};
        vecs[13] = '{mk_i(OP_BEQ, 16'h0010),     0, 0, 1, 1, 0, 32'h0000_0104};

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_req",      {31'h0, imem_req},    32'h0);
        chk("rst_valid",    {31'h0, instr_valid}, 32'h0);
        chk("rst_pc",       pc,                   32'h0);
        chk("rst_pc_plus4", pc_plus4,             32'h4);
        chk("rst_instr",    instr,                32'h0);
        chk("rst_retired",  retired,              32'h0);

        // Release: IDLE cycle, then the request in the next cycle.
        rst = 1'b0;
        @(negedge clk);
        chk("first_req", {31'h0, imem_req}, 32'h1);

        exp_pc = 32'h0;
        for (int i = 0; i < 14; i++) begin
            wait_req(0, $sformatf("v%0d", i));
            chk($sformatf("v%0d_addr", i), imem_addr, exp_pc);
            for (int d = 0; d < vecs[i].delay; d++) begin
                imem_ack = 1'b0;
                set_ctrl(1, 1, 1, 0, 1);
                @(negedge clk);
                chk($sformatf("v%0d_hold_req%0d", i, d), {31'h0, imem_req}, 32'h1);
                chk($sformatf("v%0d_hold_addr%0d", i, d), imem_addr, exp_pc);
                chk($sformatf("v%0d_hold_ret%0d", i, d), retired, i);
            end
            set_ctrl(0, 0, 0, 0, 0);
            imem_ack   = 1'b1;
            imem_rdata = vecs[i].ins;
            @(negedge clk);
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            chk($sformatf("v%0d_valid", i), {31'h0, instr_valid}, 32'h1);
            chk($sformatf("v%0d_instr", i), instr, vecs[i].ins);
            chk($sformatf("v%0d_pc", i), pc, exp_pc);
            chk($sformatf("v%0d_pc_plus4", i), pc_plus4, exp_pc + 32'd4);
            set_ctrl(1, vecs[i].j, vecs[i].b, vecs[i].bne, vecs[i].z);
            @(negedge clk);
            set_ctrl(0, 1, 1, 1, 1);
            chk($sformatf("v%0d_retired", i), retired, i + 1);
            exp_pc = vecs[i].exp_next;
        end

        // Reset coincident with commit in EXEC.
        wait_req(0, "rexec");
        chk("rexec_addr", imem_addr, exp_pc);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("rexec_valid", {31'h0, instr_valid}, 32'h1);
        rst = 1'b1;
        set_ctrl(1, 1, 0, 0, 0);
        @(negedge clk);
        set_ctrl(0, 0, 0, 0, 0);
        chk("rexec_pc",      pc,                   32'h0);
        chk("rexec_retired", retired,              32'h0);
        chk("rexec_valid0",  {31'h0, instr_valid}, 32'h0);
        chk("rexec_req0",    {31'h0, imem_req},    32'h0);

        // Stray ack while IDLE must not load the instruction register.
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("stray_instr", instr,                32'h0);
        chk("stray_valid", {31'h0, instr_valid}, 32'h0);
        chk("stray_req",   {31'h0, imem_req},    32'h1);

        // Jump from the 0x1000_0000 region, with a taken branch also asserted.
        rst    = 1'b1;
        rst_hi = 1'b0;
        @(negedge clk);
        wait_req(1, "hi");
        chk("hi_addr", hi_addr, 32'h1000_0000);
        imem_ack   = 1'b1;
        imem_rdata = mk_j(OP_J, 26'h000_0040);
        @(negedge clk);
        imem_ack = 1'b0;
        chk("hi_valid", {31'h0, hi_valid}, 32'h1);
        set_ctrl(1, 1, 1, 0, 1);
        @(negedge clk);
        set_ctrl(0, 0, 0, 0, 0);
        chk("hi_jump_addr", hi_addr, 32'h1000_0100);
        chk("hi_retired",   hi_retired, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
